pll_phase_ctrl: RTL



---
 rtl/pll_phase_ctrl_if.sv | 10 +
 rtl/pll_phase_ctrl.sv | 115 +++++++++++
 2 files changed

// File: rtl/pll_phase_ctrl_if.sv
// pll_phase_ctrl_if: phase-move command handshake (valid/ready with select, direction, step count).
interface pll_phase_ctrl_if #(parameter int STEP_W = 8);
  logic              valid;
  logic              ready;
  logic [1:0]        sel;
  logic              dir;
  logic [STEP_W-1:0] steps;
  modport master (output valid, sel, dir, steps, input ready);
  modport slave  (input valid, sel, dir, steps, output ready);
endinterface

// File: rtl/pll_phase_ctrl.sv
// pll_phase_ctrl: sequences EHXPLLL dynamic phase steps, load pulse and relock wait.
// Define PLL_PHASE_TRACK_EN to add per-output signed phase accumulators (phase_pos/phase_pos_clr).
module pll_phase_ctrl #(
  parameter int SETUP_CYC    = 4,
  parameter int PULSE_CYC    = 4,
  parameter int HOLD_CYC     = 4,
  parameter int LOCK_TIMEOUT = 1024,
  parameter int STEP_W       = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  pll_phase_ctrl_if.slave       cmd,
  input  logic                  locked,
  input  logic                  lock_lost_clr,
`ifdef PLL_PHASE_TRACK_EN
  input  logic                  phase_pos_clr,
  output logic [4*STEP_W-1:0]   phase_pos,
`endif
  output logic [1:0]            phasesel,
  output logic                  phasedir,
  output logic                  phasestep,
  output logic                  phaseloadreg,
  output logic                  done,
  output logic                  err,
  output logic                  lock_lost
);
  localparam int M1   = SETUP_CYC > PULSE_CYC ? SETUP_CYC : PULSE_CYC;
  localparam int M2   = M1 > HOLD_CYC ? M1 : HOLD_CYC;
  localparam int MAXC = M2 > LOCK_TIMEOUT ? M2 : LOCK_TIMEOUT;
  localparam int CW   = $clog2(MAXC + 1);
  typedef enum logic [2:0] {IDLE, SETUP, PULSE, HOLD, LOAD, WAITLOCK, DONE} state_t;
  state_t            state;
  logic [CW-1:0]     cnt;
  logic [STEP_W-1:0] rem;
  logic              locked_q;
  logic              fin;
  logic              enter_pulse;
  always_comb begin
    fin = state == SETUP ? cnt == CW'(SETUP_CYC - 1) :
          (state == PULSE || state == LOAD) ? cnt == CW'(PULSE_CYC - 1) :
          state == HOLD ? cnt == CW'(HOLD_CYC - 1) :
          state == WAITLOCK ? cnt == CW'(LOCK_TIMEOUT - 1) : 1'b0;
    enter_pulse = fin && (state == SETUP || (state == HOLD && rem > STEP_W'(1)));
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      cnt          <= '0;
      rem          <= '0;
      locked_q     <= 1'b0;
      cmd.ready    <= 1'b1;
      phasesel     <= 2'd0;
      phasedir     <= 1'b1;
      phasestep    <= 1'b1;
      phaseloadreg <= 1'b1;
      done         <= 1'b0;
      err          <= 1'b0;
      lock_lost    <= 1'b0;
    end else begin
      locked_q  <= locked;
      lock_lost <= (state == IDLE && locked_q && !locked) ? 1'b1 : lock_lost_clr ? 1'b0 : lock_lost;
      cnt       <= (fin || state == IDLE || state == DONE || (state == WAITLOCK && locked)) ? '0 : cnt + 1'b1;
      case (state)
        IDLE: if (cmd.valid) begin
          cmd.ready <= 1'b0;
          phasesel  <= cmd.sel;
          phasedir  <= cmd.dir;
          rem       <= cmd.steps;
          done      <= cmd.steps == '0;
          state     <= cmd.steps == '0 ? DONE : SETUP;
        end
        SETUP: if (fin) begin
          state     <= PULSE;
          phasestep <= 1'b0;
        end
        PULSE: if (fin) begin
          state     <= HOLD;
          phasestep <= 1'b1;
        end
        HOLD: if (fin) begin
          rem          <= rem - 1'b1;
          state        <= rem > STEP_W'(1) ? PULSE : LOAD;
          phasestep    <= rem <= STEP_W'(1);
          phaseloadreg <= rem > STEP_W'(1);
        end
        LOAD: if (fin) begin
          state        <= WAITLOCK;
          phaseloadreg <= 1'b1;
        end
        WAITLOCK: if (locked || fin) begin
          state <= DONE;
          done  <= 1'b1;
          err   <= !locked;
        end
        DONE: begin
          state     <= IDLE;
          done      <= 1'b0;
          err       <= 1'b0;
          cmd.ready <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end
`ifdef PLL_PHASE_TRACK_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      phase_pos <= '0;
    else if (phase_pos_clr)
      phase_pos <= '0;
    else if (enter_pulse)
      phase_pos[phasesel*STEP_W +: STEP_W] <= phase_pos[phasesel*STEP_W +: STEP_W] + (phasedir ? STEP_W'(1) : {STEP_W{1'b1}});
  end
`endif
endmodule
